dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the CPU datapath and main memory.
- Serves 8-bit LOAD/STORE accesses and generates the BUSYWAIT stall that the register file and PC use to hold writes.
- READDATA feeds the register-file write port; misses are refilled from a 32-bit, block-wide main-memory port.

---
 rtl/dcache_pkg.sv | 39 +++
 rtl/dcache_array.sv | 52 +++++
 rtl/dcache_ctrl.sv | 108 ++++++++++
 tb/tb_dcache_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped data cache.
package dcache_pkg;

  localparam int ADDR_W    = 8;
  localparam int INDEX_W   = 3;
  localparam int OFFSET_W  = 2;
  localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
  localparam int BLOCK_W   = 32;
  localparam int LINES     = 1 << INDEX_W;
  localparam int INDEX_LSB = OFFSET_W;
  localparam int TAG_LSB   = OFFSET_W + INDEX_W;
  localparam int MADDR_W   = TAG_W + INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FETCH,
    UPDATE
  } state_t;

  function automatic logic [TAG_W-1:0] tag_of(
    input logic [ADDR_W-1:0] a
  );
    return a[ADDR_W-1:TAG_LSB];
  endfunction

  function automatic logic [INDEX_W-1:0] index_of(
    input logic [ADDR_W-1:0] a
  );
    return a[TAG_LSB-1:INDEX_LSB];
  endfunction

  function automatic logic [OFFSET_W-1:0] offset_of(
    input logic [ADDR_W-1:0] a
  );
    return a[OFFSET_W-1:0];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage: valid/dirty bits (cleared by reset), tags and data blocks.
module dcache_array
  import dcache_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic [INDEX_W-1:0]  index,
  output logic                valid,
  output logic                dirty,
  output logic [TAG_W-1:0]    tag,
  output logic [BLOCK_W-1:0]  data,
  input  logic                byte_we,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [7:0]          byte_data,
  input  logic                fill_we,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [BLOCK_W-1:0]  fill_data
);

  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [BLOCK_W-1:0] data_q [LINES];

  assign valid = valid_q[index];
  assign dirty = dirty_q[index];
  assign tag   = tag_q[index];
  assign data  = data_q[index];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (byte_we) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // Tags and data keep their contents across reset.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      tag_q[index]  <= fill_tag;
      data_q[index] <= fill_data;
    end else if (byte_we) begin
      data_q[index][{offset, 3'b000} +: 8] <= byte_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic                READ,
  input  logic                WRITE,
  input  logic [ADDR_W-1:0]   ADDRESS,
  input  logic [7:0]          WRITEDATA,
  output logic [7:0]          READDATA,
  output logic                BUSYWAIT,
  output logic                MEM_READ,
  output logic                MEM_WRITE,
  output logic [MADDR_W-1:0]  MEM_ADDRESS,
  output logic [BLOCK_W-1:0]  MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]  MEM_READDATA,
  input  logic                MEM_BUSYWAIT
);

  state_t state;
  state_t state_nx;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] req_off;
  logic                line_valid;
  logic                line_dirty;
  logic [TAG_W-1:0]    line_tag;
  logic [BLOCK_W-1:0]  line_data;
  logic [BLOCK_W-1:0]  fill_buf;
  logic                hit;
  logic                req;
  logic                byte_we;
  logic                fill_we;

  assign req_tag = tag_of(ADDRESS);
  assign req_idx = index_of(ADDRESS);
  assign req_off = offset_of(ADDRESS);
  assign req     = READ | WRITE;
  assign hit     = line_valid && (line_tag == req_tag);

  dcache_array u_array (
    .CLK       (CLK),
    .RESET     (RESET),
    .index     (req_idx),
    .valid     (line_valid),
    .dirty     (line_dirty),
    .tag       (line_tag),
    .data      (line_data),
    .byte_we   (byte_we),
    .offset    (req_off),
    .byte_data (WRITEDATA),
    .fill_we   (fill_we),
    .fill_tag  (req_tag),
    .fill_data (fill_buf)
  );

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (req && !hit)
          state_nx = line_dirty ? WRITEBACK : FETCH;
      end
      WRITEBACK: if (!MEM_BUSYWAIT) state_nx = FETCH;
      FETCH:     if (!MEM_BUSYWAIT) state_nx = UPDATE;
      UPDATE:    state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Block is latched only on the edge that leaves FETCH.
  always_ff @(posedge CLK) begin
    if (state == FETCH && !MEM_BUSYWAIT)
      fill_buf <= MEM_READDATA;
  end

  always_comb begin
    BUSYWAIT      = 1'b1;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = {req_tag, req_idx};
    MEM_WRITEDATA = line_data;
    byte_we       = 1'b0;
    fill_we       = 1'b0;
    READDATA      = hit ? line_data[{req_off, 3'b000} +: 8] : 8'h00;
    unique case (state)
      IDLE: begin
        BUSYWAIT = req && !hit;
        byte_we  = WRITE && hit && !RESET;
      end
      WRITEBACK: begin
        MEM_WRITE   = 1'b1;
        MEM_ADDRESS = {line_tag, req_idx};
      end
      FETCH:   MEM_READ = 1'b1;
      UPDATE:  fill_we = !RESET;
      default: BUSYWAIT = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized + directed bench for dcache_ctrl against a line-level cache model.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_i = 1'b0;
  logic        wr_i = 1'b0;
  logic [7:0]  addr_i = '0;
  logic [7:0]  wdata_i = '0;
  logic [7:0]  rdata_o;
  logic        busy_o;
  logic        mem_rd;
  logic        mem_wr;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_busy;

  dcache_ctrl dut (
    .CLK           (clk),
    .RESET         (reset),
    .READ          (rd_i),
    .WRITE         (wr_i),
    .ADDRESS       (addr_i),
    .WRITEDATA     (wdata_i),
    .READDATA      (rdata_o),
    .BUSYWAIT      (busy_o),
    .MEM_READ      (mem_rd),
    .MEM_WRITE     (mem_wr),
    .MEM_ADDRESS   (mem_addr),
    .MEM_WRITEDATA (mem_wdata),
    .MEM_READDATA  (mem_rdata),
    .MEM_BUSYWAIT  (mem_busy)
  );

  always #5 clk = ~clk;

  // Main memory: busy for lat cycles per transfer, junk data while busy.
  logic [31:0] mem [64];
  int          cnt = 0;
  int          lat = 0;
  logic [31:0] junk = 32'h0;

  assign mem_busy  = (mem_rd | mem_wr) && (cnt != lat);
  assign mem_rdata = mem_busy ? junk : mem[mem_addr];

  always @(posedge clk) begin
    junk <= $urandom;
    if ((mem_rd | mem_wr) && cnt == lat) begin
      cnt <= 0;
      if (mem_wr) mem[mem_addr] = mem_wdata;
    end else if (mem_rd | mem_wr) begin
      cnt <= cnt + 1;
    end else begin
      cnt <= 0;
    end
  end

  // Reference model: cache lines and the memory image they imply.
  logic        m_valid [8];
  logic        m_dirty [8];
  logic [2:0]  m_tag   [8];
  logic [31:0] m_data  [8];
  logic [31:0] ref_mem [64];

  int n_checks = 0;
  int n_fail   = 0;

  int          last_stall;
  logic [7:0]  last_rd;
  logic [5:0]  last_faddr;
  logic [5:0]  last_waddr;
  logic [31:0] last_wdata;
  bit          last_wb;

  function automatic void model_reset();
    for (int k = 0; k < 8; k++) begin
      m_valid[k] = 1'b0;
      m_dirty[k] = 1'b0;
    end
  endfunction

  task automatic do_access(input logic rd, input logic wr,
                           input logic [7:0] a, input logic [7:0] wd,
                           input int l);
    logic [2:0]  t, i;
    logic [1:0]  o;
    logic        exp_hit, exp_wb;
    logic [5:0]  wb_addr;
    logic [31:0] wb_data;
    logic [7:0]  exp_rd, rdv;
    int          exp_stall, stall;
    bit          saw_wb, saw_f, both, done;
    logic [5:0]  o_waddr, o_faddr;
    logic [31:0] o_wdata;
    t = a[7:5];
    i = a[4:2];
    o = a[1:0];
    exp_hit   = m_valid[i] && (m_tag[i] == t);
    exp_wb    = !exp_hit && m_dirty[i];
    wb_addr   = {m_tag[i], i};
    wb_data   = m_data[i];
    exp_stall = exp_hit ? 0 : (l + 3) + (exp_wb ? l + 1 : 0);
    lat = l;
    rd_i = rd; wr_i = wr; addr_i = a; wdata_i = wd;
    stall = 0; saw_wb = 0; saw_f = 0; both = 0; done = 0;
    o_waddr = '0; o_faddr = '0; o_wdata = '0; rdv = '0;
    while (!done && stall < 200) begin
      @(negedge clk);
      if (mem_rd && mem_wr) both = 1;
      if (mem_wr && !saw_wb) begin
        saw_wb = 1; o_waddr = mem_addr; o_wdata = mem_wdata;
      end
      if (mem_rd && !saw_f) begin
        saw_f = 1; o_faddr = mem_addr;
      end
      if (!busy_o) begin
        done = 1; rdv = rdata_o;
      end else begin
        stall++;
      end
      @(posedge clk);
      #1;
    end
    rd_i = 1'b0; wr_i = 1'b0;
    if (!exp_hit) begin
      if (exp_wb) ref_mem[wb_addr] = wb_data;
      m_data[i]  = ref_mem[{t, i}];
      m_tag[i]   = t;
      m_valid[i] = 1'b1;
      m_dirty[i] = 1'b0;
    end
    exp_rd = m_data[i][o*8 +: 8];
    if (wr) begin
      m_data[i][o*8 +: 8] = wd;
      m_dirty[i] = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL timeout addr=%h: BUSYWAIT stuck high", a);
    end
    n_checks++;
    if (stall !== exp_stall) begin
      n_fail++;
      $display("FAIL stall addr=%h: got %0d exp %0d", a, stall, exp_stall);
    end
    n_checks++;
    if (saw_wb !== exp_wb) begin
      n_fail++;
      $display("FAIL wb_seen addr=%h: got %0d exp %0d", a, saw_wb, exp_wb);
    end
    if (exp_wb && saw_wb) begin
      n_checks++;
      if (o_waddr !== wb_addr || o_wdata !== wb_data) begin
        n_fail++;
        $display("FAIL wb_block addr=%h: got %h/%h exp %h/%h",
                 a, o_waddr, o_wdata, wb_addr, wb_data);
      end
    end
    n_checks++;
    if (saw_f !== !exp_hit) begin
      n_fail++;
      $display("FAIL fetch_seen addr=%h: got %0d exp %0d", a, saw_f, !exp_hit);
    end
    if (saw_f && !exp_hit) begin
      n_checks++;
      if (o_faddr !== {t, i}) begin
        n_fail++;
        $display("FAIL fetch_addr addr=%h: got %h exp %h", a, o_faddr, {t, i});
      end
    end
    n_checks++;
    if (both) begin
      n_fail++;
      $display("FAIL strobes addr=%h: got both high exp exclusive", a);
    end
    if (rd && !wr) begin
      n_checks++;
      if (rdv !== exp_rd) begin
        n_fail++;
        $display("FAIL readdata addr=%h: got %h exp %h", a, rdv, exp_rd);
      end
    end
    last_stall = stall; last_rd = rdv; last_faddr = o_faddr;
    last_waddr = o_waddr; last_wdata = o_wdata; last_wb = saw_wb;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks++;
    if ({busy_o, mem_rd, mem_wr, rdata_o} !== 11'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b mrd=%b mwr=%b rd=%h exp 0",
               busy_o, mem_rd, mem_wr, rdata_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_miss_refill();
    do_access(1, 0, 8'h25, 8'h00, 5);
    n_checks++;
    if (last_rd !== 8'hBB || last_faddr !== 6'h09 || last_wb) begin
      n_fail++;
      $display("FAIL miss_refill: got rd=%h faddr=%h wb=%0d exp BB/09/0",
               last_rd, last_faddr, last_wb);
    end
  endtask

  task automatic test_read_hit();
    do_access(1, 0, 8'h24, 8'h00, 5);
    n_checks++;
    if (last_rd !== 8'hAA || last_stall !== 0) begin
      n_fail++;
      $display("FAIL read_hit: got rd=%h stall=%0d exp AA/0", last_rd, last_stall);
    end
  endtask

  task automatic test_write_hit();
    do_access(0, 1, 8'h26, 8'h5A, 5);
    do_access(1, 0, 8'h26, 8'h00, 5);
    n_checks++;
    if (last_rd !== 8'h5A || last_stall !== 0) begin
      n_fail++;
      $display("FAIL write_hit: got rd=%h stall=%0d exp 5A/0", last_rd, last_stall);
    end
  endtask

  task automatic test_writeback();
    do_access(1, 0, 8'hA5, 8'h00, 2);
    n_checks++;
    if (!last_wb || last_waddr !== 6'h09 || last_wdata !== 32'hDD5ABBAA ||
        last_faddr !== 6'h29) begin
      n_fail++;
      $display("FAIL writeback: got wb=%0d %h/%h f=%h exp 1 09/DD5ABBAA f=29",
               last_wb, last_waddr, last_wdata, last_faddr);
    end
  endtask

  task automatic test_clean_evict();
    do_access(1, 0, 8'hC8, 8'h00, 1);
    do_access(1, 0, 8'h08, 8'h00, 3);
    n_checks++;
    if (last_wb || last_faddr !== 6'h02) begin
      n_fail++;
      $display("FAIL clean_evict: got wb=%0d f=%h exp 0/02", last_wb, last_faddr);
    end
  endtask

  task automatic test_reset_mid_fetch();
    int w;
    lat = 5;
    rd_i = 1'b1; addr_i = 8'h24;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!mem_rd && w < 20);
    n_checks++;
    if (!mem_rd) begin
      n_fail++;
      $display("FAIL mid_fetch_start: got MEM_READ=0 exp 1");
    end
    @(posedge clk); #1;
    reset = 1'b1; rd_i = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks++;
    if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_fetch_abort: got mrd=%b mwr=%b busy=%b exp 0/0/0",
               mem_rd, mem_wr, busy_o);
    end
    @(posedge clk); #1;
    do_access(1, 0, 8'h24, 8'h00, 1);
    n_checks++;
    if (last_stall == 0) begin
      n_fail++;
      $display("FAIL post_reset_miss: got stall=0 exp miss");
    end
  endtask

  task automatic test_random();
    logic [2:0] tags [3];
    logic [7:0] a;
    logic       r;
    tags[0] = 3'd0; tags[1] = 3'd1; tags[2] = 3'd5;
    for (int n = 0; n < 150; n++) begin
      a = {tags[$urandom_range(0, 2)], 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3))};
      r = 1'($urandom_range(0, 1));
      do_access(r, !r, a, 8'($urandom), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 64; k++) begin
      mem[k]     = $urandom;
      ref_mem[k] = mem[k];
    end
    mem[6'h09]     = 32'hDDCCBBAA;
    ref_mem[6'h09] = 32'hDDCCBBAA;
    model_reset();
    test_reset();
    test_miss_refill();
    test_read_hit();
    test_write_hit();
    test_writeback();
    test_clean_evict();
    test_reset_mid_fetch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
